// File: rtl/hw2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hw2_pkg
// Description : Shared constants and types for the two-requester arithmetic
//               pipeline arbiter (operation codes, widths, latency, tracking
//               entry layout, zero-extension helper).
// Revision    : 1.0 - initial release
// ============================================================================
package hw2_pkg;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;
    localparam int   OPW    = 8;
    localparam int   RESW   = 16;
    localparam int   LAT    = 2;

    // One in-flight operation: valid flag plus issuing requester.
    typedef struct packed {
        logic vld;
        logic id;
    } trk_t;

    function automatic logic [RESW-1:0] zext(input logic [OPW-1:0] x);
        return {{(RESW-OPW){1'b0}}, x};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hw2_arb_dp.sv
`default_nettype none
// ============================================================================
// Module      : hw2_arb_dp
// Description : Two-stage datapath computing (a +/- b) * c modulo 2^16.
//               Stage 1 captures the sum/difference and multiplier on issue,
//               stage 2 captures the truncated product.
// Revision    : 1.0 - initial release
// ============================================================================
module hw2_arb_dp
    import hw2_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_i,
    input  logic            s2_en_i,
    input  logic            op_i,
    input  logic [OPW-1:0]  a_i,
    input  logic [OPW-1:0]  b_i,
    input  logic [OPW-1:0]  c_i,
    output logic [RESW-1:0] prod_o
);

    logic [RESW-1:0] sum_q, sum_d;
    logic [RESW-1:0] mul_q, mul_d;
    logic [RESW-1:0] prod_q, prod_d;

    // Stage 1: operands are only sampled on the issue edge, otherwise held.
    always_comb begin
        sum_d = sum_q;
        mul_d = mul_q;
        if (issue_i) begin
            if (op_i == OP_ADD) begin
                sum_d = zext(a_i) + zext(b_i);
            end else if (op_i == OP_SUB) begin
                sum_d = zext(a_i) - zext(b_i);
            end
            mul_d = zext(c_i);
        end
    end

    // Stage 2: product truncated to the result width.
    always_comb begin
        prod_d = prod_q;
        if (s2_en_i) begin
            prod_d = sum_q * mul_q;
        end
    end

    // Pipeline registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_q  <= '0;
            mul_q  <= '0;
            prod_q <= '0;
        end else begin
            sum_q  <= sum_d;
            mul_q  <= mul_d;
            prod_q <= prod_d;
        end
    end

    assign prod_o = prod_q;

endmodule
`default_nettype wire

// File: rtl/hw2_pipe_arb.sv
`default_nettype none
// ============================================================================
// Module      : hw2_pipe_arb
// Description : Round-robin arbiter between two requesters feeding a shared
//               (a +/- b) * c pipeline. Tracks in-flight ops, registers the
//               response and counts completions per requester.
// Revision    : 1.0 - initial release
// ============================================================================
module hw2_pipe_arb
    import hw2_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            v0,
    input  logic            v1,
    input  logic [OPW-1:0]  a0,
    input  logic [OPW-1:0]  b0,
    input  logic [OPW-1:0]  c0,
    input  logic [OPW-1:0]  a1,
    input  logic [OPW-1:0]  b1,
    input  logic [OPW-1:0]  c1,
    input  logic            s0,
    input  logic            s1,
    input  logic            hold,
    output logic            rdy0,
    output logic            rdy1,
    output logic            rsp_valid,
    output logic            rsp_id,
    output logic [RESW-1:0] rsp_d,
    output logic            busy,
    output logic [OPW-1:0]  cnt0,
    output logic [OPW-1:0]  cnt1
);

    trk_t [LAT-1:0]  trk_q, trk_d;
    trk_t            w_tail;
    logic            last_q, last_d;      // requester granted most recently
    logic            rv_q, rv_d;
    logic            rid_q, rid_d;
    logic [RESW-1:0] res_q, res_d;
    logic [OPW-1:0]  cnt0_q, cnt0_d;
    logic [OPW-1:0]  cnt1_q, cnt1_d;
    logic            w_issue, w_id, w_op;
    logic [OPW-1:0]  w_a, w_b, w_c;
    logic [RESW-1:0] w_prod;

    // Grant: blocked by reset or hold, single requester wins outright, a tie
    // goes to the requester that was not granted last.
    always_comb begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        if (reset && !hold) begin
            if (v0 && v1) begin
                rdy0 = last_q;
                rdy1 = !last_q;
            end else begin
                rdy0 = v0;
                rdy1 = v1;
            end
        end
    end

    // Transfer decode, pointer update and operand selection.
    always_comb begin
        w_issue = (v0 && rdy0) || (v1 && rdy1);
        w_id    = v1 && rdy1;
        last_d  = w_issue ? w_id : last_q;
        w_a     = w_id ? a1 : a0;
        w_b     = w_id ? b1 : b0;
        w_c     = w_id ? c1 : c0;
        w_op    = w_id ? s1 : s0;
    end

    // In-flight tracking shift register, aligned with the datapath stages.
    always_comb begin
        trk_d[0].vld = w_issue;
        trk_d[0].id  = w_id;
        for (int i = 1; i < LAT; i++) begin
            trk_d[i] = trk_q[i-1];
        end
    end

    // Response register and completion counters fed from the tracking tail.
    always_comb begin
        w_tail = trk_q[LAT-1];
        rv_d   = w_tail.vld;
        rid_d  = w_tail.vld && w_tail.id;
        res_d  = w_tail.vld ? w_prod : '0;
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (w_tail.vld && !w_tail.id) begin
            cnt0_d = cnt0_q + 8'd1;
        end
        if (w_tail.vld && w_tail.id) begin
            cnt1_d = cnt1_q + 8'd1;
        end
    end

    // Busy while any tracking entry holds a live op.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            busy = busy | trk_q[i].vld;
        end
    end

    // State registers; reset discards in-flight ops and favours requester 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q <= 1'b1;
            trk_q  <= '0;
            rv_q   <= 1'b0;
            rid_q  <= 1'b0;
            res_q  <= '0;
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            last_q <= last_d;
            trk_q  <= trk_d;
            rv_q   <= rv_d;
            rid_q  <= rid_d;
            res_q  <= res_d;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    hw2_arb_dp u_dp (
        .clk     (clk),
        .reset   (reset),
        .issue_i (w_issue),
        .s2_en_i (trk_q[0].vld),
        .op_i    (w_op),
        .a_i     (w_a),
        .b_i     (w_b),
        .c_i     (w_c),
        .prod_o  (w_prod)
    );

    assign rsp_valid = rv_q;
    assign rsp_id    = rid_q;
    assign rsp_d     = res_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

endmodule
`default_nettype wire

// File: doc/hw2_pipe_arb.md
HW2_PIPE_ARB -- requirements
Module: hw2_pipe_arb

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- LAT, 2, datapath latency in cycles from issue to result (fixed; not user-overridable).
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 at a clk edge resets).
- v0, v1  in  1  requester 0/1 operation valid.
- a0, b0, c0, a1, b1, c1  in  8  per-requester operands.
- s0, s1  in  1  per-requester op select (1 = add, 0 = subtract).
- hold  in  1  when 1, no new issue; in-flight ops still drain.
- rdy0, rdy1  out  1  grant; a transfer occurs when vN && rdyN in the same cycle.
- rsp_valid  out  1  result valid this cycle.
- rsp_id  out  1  requester that issued the result.
- rsp_d  out  16  result (a±b)*c.
- busy  out  1  1 while any op is in flight.
- cnt0, cnt1  out  8  completed-op counters per requester.

Function
REQ-003 rdyN SHALL be combinational from v0, v1, hold and the round-robin pointer; at most one rdy SHALL be 1 per cycle.
REQ-004 When hold==1, rdy0 and rdy1 SHALL both be 0.
REQ-005 When only one request is valid, that request SHALL be granted; when neither is valid, no rdy SHALL be asserted.
REQ-006 When both are valid, the requester not granted most recently SHALL be granted; the pointer SHALL update only on a transfer.
REQ-007 At most one op SHALL issue per cycle; back-to-back issues SHALL be accepted every cycle without bubbles.
REQ-008 An op issued at edge N SHALL produce rsp_valid=1 with its rsp_id and rsp_d after edge N+2, for exactly one cycle.
REQ-009 Arithmetic: a, b, c SHALL be zero-extended to 16 bits; the sum or difference SHALL be taken modulo 2^16; rsp_d SHALL be the product modulo 2^16.
REQ-010 rsp_d SHALL be 0 in any cycle where rsp_valid==0.
REQ-011 A 2-entry valid+id shift register SHALL track in-flight ops; busy SHALL be the OR of its valid bits.
REQ-012 cntN SHALL increment by 1 in the cycle rsp_valid==1 with rsp_id==N, and SHALL wrap from 0xFF to 0x00.
REQ-013 Responses SHALL have no backpressure and SHALL be returned in issue order.
REQ-014 Operands SHALL be sampled only at the transfer edge; later changes to the inputs SHALL NOT affect the issued op.

Reset
REQ-015 On reset: rsp_valid=0, rsp_id=0, rsp_d=0, busy=0, cnt0=cnt1=0, tracking valids cleared, and the pointer set so requester 0 wins the next tie.
REQ-016 rdy0 and rdy1 SHALL be 0 in any cycle where reset==0.
REQ-017 Reset mid-operation SHALL discard all in-flight ops; no response for them SHALL appear after reset releases.

Structure
REQ-018 A shared package hw2_pkg SHALL hold OP_ADD/OP_SUB constants, the operand width (8), the result width (16) and LAT.
REQ-019 The two-stage (a±b)*c arithmetic SHALL be one sub-module, hw2_arb_dp: stage 1 computes the sum/difference, stage 2 computes the product.
REQ-020 The arbiter, tracking register and counters SHALL reside in hw2_pipe_arb.

Verification
REQ-021 Single op: v0=1, a0=3, b0=2, c0=4, s0=1 for one cycle -> two cycles later rsp_valid=1, rsp_id=0, rsp_d=0x0014, cnt0=1.
REQ-022 Subtract wrap: v1 only, a1=1, b1=2, c1=1, s1=0 -> rsp_d=0xFFFF, rsp_id=1; with c1=0 -> rsp_d=0x0000.
REQ-023 Contention: v0=v1=1 held for 6 cycles -> grants 0,1,0,1,0,1; responses back-to-back with rsp_id 0,1,0,1,0,1; cnt0=cnt1=3.
REQ-024 Hold: both valid, hold=1 for 3 cycles -> rdy0=rdy1=0, no new issues; ops already in flight still respond; issue resumes the cycle after hold=0.
REQ-025 Reset mid-flight: issue two ops, assert reset for 1 cycle at the next edge -> rsp_valid stays 0, busy=0, counters=0, and requester 0 wins the next tie.
REQ-026 Counter wrap: 256 completed ops from requester 0 -> cnt0 returns to 0x00.
